// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_pkg
//  Description : Shared types and constants for the two-requester ALU
//                arbiter: opcode encoding, FSM state type, flag-bit layout
//                and the round-robin pick helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    // Opcode encoding seen on reqX_op; value 0 is accepted but does nothing
    typedef enum logic [2:0] {
        OP_INVALID = 3'd0,
        OP_ADD     = 3'd1,
        OP_SUB     = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_XOR     = 3'd5,
        OP_SLL     = 3'd6,
        OP_SRL     = 3'd7
    } alu_op_e;

    // Arbiter sequencing: accept in IDLE, compute in EXEC, present in RESP
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // rsp_flags layout
    localparam int FLAG_W = 4;
    localparam int FLAG_Z = 0;   // result is zero
    localparam int FLAG_N = 1;   // result MSB set
    localparam int FLAG_C = 2;   // carry out (add) / borrow (sub)
    localparam int FLAG_V = 3;   // signed overflow (add/sub)

    // Round-robin pick: a lone requester wins outright; when both are
    // pending, prio1 selects which one goes first.
    function automatic logic rr_pick(input logic v0, input logic v1,
                                     input logic prio1);
        return (v0 & v1) ? prio1 : v1;
    endfunction

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_module.sv
`default_nettype none
// ============================================================================
//  Module      : alu_module
//  Description : Purely combinational N-bit ALU shared by both requesters.
//                Produces a result and four status flags; an invalid opcode
//                yields an all-zero result and all-zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_module
    import alu_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [2:0]        op,
    output logic [N-1:0]      result,
    output logic [FLAG_W-1:0] flags
);

    // One extra bit on add/sub exposes carry-out and borrow directly
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic [N-1:0] w_res;
    logic         w_carry;
    logic         w_ovf;
    logic         w_op_ok;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Operation select; shifts by b >= N naturally produce zero
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_op_ok = 1'b1;
        case (alu_op_e'(op))
            OP_ADD: begin
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[N-1:0];
                w_carry = w_diff[N];
                w_ovf   = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SLL:  w_res = a << b;
            OP_SRL:  w_res = a >> b;
            default: w_op_ok = 1'b0;
        endcase
    end

    // Flag packing; an invalid opcode must not raise the zero flag
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = w_op_ok & (w_res == '0);
        flags[FLAG_N] = w_op_ok & w_res[N-1];
        flags[FLAG_C] = w_op_ok & w_carry;
        flags[FLAG_V] = w_op_ok & w_ovf;
    end

    assign result = w_res;

endmodule : alu_module
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter granting two requesters access to one
//                shared ALU. Each operation runs IDLE -> EXEC -> RESP and the
//                response is held until rsp_ready.
//                Build option: define ALU_ARB_BUSY_CNT_EN to enable the
//                saturating busy_cnt counter (otherwise busy_cnt is 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [N-1:0]      req0_a,
    input  logic [N-1:0]      req0_b,
    input  logic [2:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [N-1:0]      req1_a,
    input  logic [N-1:0]      req1_b,
    input  logic [2:0]        req1_op,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,

    output logic [15:0]       busy_cnt
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;

    // Set after req0 wins, so req1 goes first on the next contention
    logic                r_prio1;
    logic                w_grant_id;
    logic                w_accept;
    logic                w_idle_live;

    // Operation captured at the handshake
    logic [N-1:0]        r_a;
    logic [N-1:0]        r_b;
    logic [2:0]          r_op;
    logic                r_id;

    // Response registers loaded at the end of EXEC
    logic [N-1:0]        r_result;
    logic [FLAG_W-1:0]   r_flags;
    logic                r_rsp_id;

    logic [N-1:0]        w_alu_result;
    logic [FLAG_W-1:0]   w_alu_flags;

    // Readies are forced low while reset is held, even though the state is IDLE
    assign w_idle_live = (r_state == ST_IDLE) && rst_n;
    assign w_grant_id  = rr_pick(req0_valid, req1_valid, r_prio1);
    assign w_accept    = w_idle_live && (req0_valid || req1_valid);

    // Next-state and handshake/response outputs
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the granted operation and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_id    <= 1'b0;
        end else if (w_accept) begin
            r_prio1 <= ~w_grant_id;
            r_a     <= w_grant_id ? req1_a  : req0_a;
            r_b     <= w_grant_id ? req1_b  : req0_b;
            r_op    <= w_grant_id ? req1_op : req0_op;
            r_id    <= w_grant_id;
        end
    end

    // The single shared datapath, always fed from the captured operation
    alu_module #(
        .N (N)
    ) u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    // Register the ALU output at the end of EXEC; it stays stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
            r_rsp_id <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result <= w_alu_result;
            r_flags  <= w_alu_flags;
            r_rsp_id <= r_id;
        end
    end

    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_id     = r_rsp_id;

`ifdef ALU_ARB_BUSY_CNT_EN
    logic [15:0] r_busy_cnt;

    // Count every cycle spent in EXEC or RESP, holding at the top value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cnt <= '0;
        end else if (((r_state == ST_EXEC) || (r_state == ST_RESP)) &&
                     (r_busy_cnt != 16'hFFFF)) begin
            r_busy_cnt <= r_busy_cnt + 16'd1;
        end
    end

    assign busy_cnt = r_busy_cnt;
`else
    assign busy_cnt = '0;
`endif

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter (N = 4).
//                Flag vectors are written as {V, C, N, Z}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic [2:0]   req0_op = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    logic [2:0]   req1_op = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [15:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Pulse reset low for one full cycle, releasing on a falling edge
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one operation from a single requester with rsp_ready high; returns
    // sampled values at the RESP cycle (two cycles after the handshake).
    task automatic do_op(input logic id, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [2:0] op,
                         output logic granted, output logic vld,
                         output logic got_id, output logic [N-1:0] res,
                         output logic [3:0] flg);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1 granted = id ? req1_ready : req0_ready;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        vld    = rsp_valid;
        got_id = rsp_id;
        res    = rsp_result;
        flg    = rsp_flags;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
        checks++; if (rsp_result !== 4'd0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
        checks++; if (rsp_flags !== 4'd0) begin errors++; $display("FAIL reset_rsp_flags got=%b exp=0000", rsp_flags); end
        checks++; if (busy_cnt !== 16'd0) begin errors++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // req0 only, 3 + 2: checks latency and result
    task automatic test_single();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd2; req0_op = 3'd1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_grant got=%b%b exp=01", req1_ready, req0_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_T1 got=%b exp=0", rsp_valid); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_exec got=%b exp=0", req0_ready); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid_T2 got=%b exp=1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got=%b exp=0", rsp_id); end
        checks++; if (rsp_result !== 4'd5) begin errors++; $display("FAIL single_result got=%0d exp=5", rsp_result); end
        checks++; if (rsp_flags !== 4'b0000) begin errors++; $display("FAIL single_flags got=%b exp=0000", rsp_flags); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got=%b exp=0", rsp_valid); end
    endtask

    // Directed ALU vectors alternating between the two requesters
    task automatic test_alu_ops();
        logic [N-1:0] ta [9] = '{4'd7, 4'd15, 4'd2, 4'd12, 4'd5, 4'd6, 4'd8, 4'd1, 4'd8};
        logic [N-1:0] tb [9] = '{4'd1, 4'd1,  4'd3, 4'd10, 4'd2, 4'd6, 4'd3, 4'd4, 4'd1};
        logic [2:0]   top[9] = '{3'd1, 3'd1,  3'd2, 3'd3,  3'd4, 3'd5, 3'd7, 3'd6, 3'd2};
        logic [N-1:0] er [9] = '{4'd8, 4'd0,  4'd15, 4'd8, 4'd7, 4'd0, 4'd1, 4'd0, 4'd7};
        logic [3:0]   ef [9] = '{4'b1010, 4'b0101, 4'b0110, 4'b0010, 4'b0000,
                                 4'b0001, 4'b0000, 4'b0001, 4'b1000};
        logic g, v, id;
        logic [N-1:0] r;
        logic [3:0] f;
        for (int i = 0; i < 9; i++) begin
            do_op(1'(i % 2), ta[i], tb[i], top[i], g, v, id, r, f);
            checks++; if (g !== 1'b1) begin errors++; $display("FAIL alu%0d_grant got=%b exp=1", i, g); end
            checks++; if (v !== 1'b1 || id !== 1'(i % 2)) begin errors++; $display("FAIL alu%0d_valid_id got=%b/%b exp=1/%0d", i, v, id, i % 2); end
            checks++; if (r !== er[i]) begin errors++; $display("FAIL alu%0d_result got=%h exp=%h", i, r, er[i]); end
            checks++; if (f !== ef[i]) begin errors++; $display("FAIL alu%0d_flags got=%b exp=%b", i, f, ef[i]); end
        end
    endtask

    // Both requesters always valid after reset: grants go 0,1,0,1
    task automatic test_round_robin();
        logic exp_id;
        pulse_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd1; req0_op = 3'd2;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd1; req1_op = 3'd2;
        for (int k = 0; k < 4; k++) begin
            exp_id = 1'(k % 2);
            #1;
            checks++; if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin errors++; $display("FAIL rr%0d_grant got=%b%b exp_id=%b", k, req1_ready, req0_ready, exp_id); end
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rr%0d_ready_exec got=%b%b exp=00", k, req1_ready, req0_ready); end
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin errors++; $display("FAIL rr%0d_rsp got=%b/%b exp=1/%b", k, rsp_valid, rsp_id, exp_id); end
            checks++; if (rsp_result !== 4'd4) begin errors++; $display("FAIL rr%0d_result got=%0d exp=4", k, rsp_result); end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // req1 sll with rsp_ready low for 5 cycles; both requesters tempt a grant
    task automatic test_stall();
        @(negedge clk);
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b0011; req1_b = 4'd1; req1_op = 3'd6;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stall_grant got=%b exp=1", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL stall%0d_rsp got=%b/%b exp=1/1", c, rsp_valid, rsp_id); end
            checks++; if (rsp_result !== 4'b0110 || rsp_flags !== 4'b0000) begin errors++; $display("FAIL stall%0d_data got=%b/%b exp=0110/0000", c, rsp_result, rsp_flags); end
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_ready got=%b%b exp=00", c, req1_ready, req0_ready); end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b0110) begin errors++; $display("FAIL stall_release got=%b/%b exp=1/0110", rsp_valid, rsp_result); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_done got=%b exp=0", rsp_valid); end
    endtask

    // Opcode 0 is accepted and completes with zero result and flags
    task automatic test_invalid_op();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd7; req0_op = 3'd0;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL inv_grant got=%b exp=1", req0_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL inv_valid_T1 got=%b exp=0", rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL inv_valid_T2 got=%b exp=1", rsp_valid); end
        checks++; if (rsp_result !== 4'd0 || rsp_flags !== 4'd0) begin errors++; $display("FAIL inv_data got=%h/%b exp=0/0000", rsp_result, rsp_flags); end
        @(negedge clk);
    endtask

    // Reset asserted while in RESP discards the operation
    task automatic test_reset_in_resp();
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'd1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstresp_pre got=%b exp=1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstresp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_result !== 4'd0 || busy_cnt !== 16'd0) begin errors++; $display("FAIL rstresp_clear got=%h/%0d exp=0/0", rsp_result, busy_cnt); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rstresp_ready got=%b exp=0", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstresp_post%0d got=%b exp=0", c, rsp_valid); end
        end
        req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rstresp_idle got=%b exp=1", req0_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Three back-to-back ops: six busy cycles when the counter is built in
    task automatic test_back_to_back();
        logic [15:0] exp_cnt;
`ifdef ALU_ARB_BUSY_CNT_EN
        exp_cnt = 16'd6;
`else
        exp_cnt = 16'd0;
`endif
        pulse_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_grant got=%b exp=1", k, req0_ready); end
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'd3) begin errors++; $display("FAIL b2b%0d_rsp got=%b/%0d exp=1/3", k, rsp_valid, rsp_result); end
            if (k == 2) req0_valid = 1'b0;
            @(negedge clk);
        end
        #1;
        checks++; if (busy_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_busy_cnt got=%0d exp=%0d", busy_cnt, exp_cnt); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_busy_idle got=%0d exp=%0d", busy_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alu_ops();
        test_round_robin();
        test_stall();
        test_invalid_op();
        test_reset_in_resp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  N each  operands.
REQ-007 SHALL have ports req0_op / req1_op  input  3 each  opcode: 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 sll, 7 srl, 0 invalid.
REQ-008 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (granted requester), rsp_result  output  N, rsp_flags  output  4.
REQ-009 SHALL have port busy_cnt  output  16  occupied-cycle counter (see Configuration).

Function
REQ-010 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-011 In IDLE, SHALL assert exactly one reqX_ready, combinationally, only for the granted valid requester; handshake = valid & ready in same cycle.
REQ-012 Arbitration SHALL be round-robin: one valid -> grant it; both valid -> grant the one not granted last; pointer after reset favours req0.
REQ-013 On handshake SHALL latch a, b, op and id, and go to EXEC next cycle.
REQ-014 In EXEC SHALL drive latched operands/opcode to the shared ALU and register its result and flags at the end of the cycle, then go to RESP.
REQ-015 In RESP SHALL hold rsp_valid high with stable rsp_id/rsp_result/rsp_flags until rsp_ready; on rsp_valid & rsp_ready SHALL return to IDLE.
REQ-016 Latency: handshake at cycle T -> rsp_valid first high at T+2; minimum throughput one operation per 3 cycles.
REQ-017 No reqX_ready SHALL be asserted outside IDLE; requester valid may drop or change while not ready without effect.
REQ-018 Opcode 0 SHALL still be accepted and complete with rsp_result = 0, rsp_flags = 0.
REQ-019 rsp_ready held low SHALL stall indefinitely in RESP with no loss and no new grants.

Reset
REQ-020 On rst_n low SHALL asynchronously enter IDLE, clear pointer, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0, busy_cnt = 0, reqX_ready = 0 while rst_n low.
REQ-021 Reset during EXEC or RESP SHALL discard the in-flight operation; no response issued after release.

Configuration
REQ-022 Macro ALU_ARB_BUSY_CNT_EN defined: busy_cnt SHALL increment by 1 every cycle in EXEC or RESP, saturating at 16'hFFFF.
REQ-023 Macro undefined: busy_cnt SHALL be tied to 0 and no counter logic synthesized.

Structure
REQ-024 Shared package SHALL hold the opcode enumeration (values 0-7), FSM state typedef, and flag-bit index constants.
REQ-025 SHALL instantiate exactly one ALU sub-module, alu_module, parameterised with N, as the shared datapath.

Verification
REQ-026 req0 only, a=3 b=2 op=1, rsp_ready=1 -> rsp_valid at T+2, id=0, result=5.
REQ-027 Both valid every cycle after reset, op=2 a=5 b=1 -> grants alternate 0,1,0,1; each result=4.
REQ-028 req1 a=4'b0011 b=1 op=6, rsp_ready low 5 cycles -> rsp_valid held, result=4'b0110 stable, no ready asserted meanwhile.
REQ-029 op=0 a=7 b=7 -> result=0, flags=0, rsp_valid at T+2.
REQ-030 rst_n low during RESP -> rsp_valid drops immediately, state IDLE, no response after release; busy_cnt=0.
REQ-031 With ALU_ARB_BUSY_CNT_EN, 3 back-to-back ops, rsp_ready=1 -> busy_cnt=6; without macro -> busy_cnt=0.
